// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares the data-memory bus between the CPU (priority) and one aux master,
// forcing a one-cycle CPU stall when the aux master has been denied MAX_WAIT cycles.
module data_bus_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCReadEnable,
    input  logic        iCWriteEnable,
    input  logic [3:0]  iCByteEnable,
    input  logic [31:0] iCAddress,
    input  logic [31:0] iCWriteData,
    output logic [31:0] oCReadData,
    output logic        oCPUStall,
    input  logic        iAReq,
    input  logic        iAWrite,
    input  logic [3:0]  iAByteEnable,
    input  logic [31:0] iAAddress,
    input  logic [31:0] iAWriteData,
    output logic        oAAck,
    output logic [31:0] oAReadData,
    output logic        oDReadEnable,
    output logic        oDWriteEnable,
    output logic [3:0]  oDByteEnable,
    output logic [31:0] oDAddress,
    output logic [31:0] oDWriteData,
    input  logic [31:0] iDReadData
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t     state;
    logic [7:0] wait_cnt;
    logic       cpu_act, grant;

    assign cpu_act = iCReadEnable | iCWriteEnable;
    assign grant   = ~iRST & (state == IDLE) & iAReq & (~cpu_act | (wait_cnt == 8'(MAX_WAIT)));

    assign oCPUStall     = grant & cpu_act;
    assign oCReadData    = iDReadData;
    assign oDReadEnable  = iRST ? 1'b0 : grant ? ~iAWrite : iCReadEnable;
    assign oDWriteEnable = iRST ? 1'b0 : grant ? iAWrite : iCWriteEnable;
    assign oDByteEnable  = grant ? iAByteEnable : iCByteEnable;
    assign oDAddress     = grant ? iAAddress : iCAddress;
    assign oDWriteData   = grant ? iAWriteData : iCWriteData;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            oAAck      <= 1'b0;
            oAReadData <= 32'd0;
        end else begin
            state <= grant ? ACK : IDLE;
            oAAck <= grant;
            if (grant & ~iAWrite)
                oAReadData <= iDReadData;
            // the count only runs while a pending request is being denied by CPU traffic
            wait_cnt <= (grant | ~iAReq | (state == ACK)) ? 8'd0 :
                        (cpu_act & (wait_cnt != 8'(MAX_WAIT))) ? wait_cnt + 8'd1 : wait_cnt;
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed literal checks plus randomized traffic checked every cycle
// against a behavioural model of the arbitration rules.
module tb_data_bus_arbiter;
    localparam int MAX_WAIT = 4;

    logic        iCLK = 1'b0, iRST;
    logic        iCReadEnable, iCWriteEnable;
    logic [3:0]  iCByteEnable;
    logic [31:0] iCAddress, iCWriteData, oCReadData;
    logic        oCPUStall, iAReq, iAWrite, oAAck;
    logic [3:0]  iAByteEnable, oDByteEnable;
    logic [31:0] iAAddress, iAWriteData, oAReadData;
    logic        oDReadEnable, oDWriteEnable;
    logic [31:0] oDAddress, oDWriteData, iDReadData;

    int compared = 0, mismatched = 0;

    data_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCReadEnable(iCReadEnable), .iCWriteEnable(iCWriteEnable),
        .iCByteEnable(iCByteEnable), .iCAddress(iCAddress), .iCWriteData(iCWriteData),
        .oCReadData(oCReadData), .oCPUStall(oCPUStall),
        .iAReq(iAReq), .iAWrite(iAWrite), .iAByteEnable(iAByteEnable),
        .iAAddress(iAAddress), .iAWriteData(iAWriteData),
        .oAAck(oAAck), .oAReadData(oAReadData),
        .oDReadEnable(oDReadEnable), .oDWriteEnable(oDWriteEnable),
        .oDByteEnable(oDByteEnable), .oDAddress(oDAddress), .oDWriteData(oDWriteData),
        .iDReadData(iDReadData)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: ack pending, count of consecutive denied cycles, last aux read value.
    bit          m_known = 0, m_ack = 0;
    int          m_wait = 0;
    logic [31:0] m_rd = '0;
    bit          m_cpu, m_grant;

    always @(negedge iCLK) begin
        m_cpu   = iCReadEnable || iCWriteEnable;
        m_grant = !iRST && !m_ack && iAReq && (!m_cpu || m_wait >= MAX_WAIT);
        chk("stall", oCPUStall, m_grant && m_cpu);
        chk("mem_re", oDReadEnable, iRST ? 1'b0 : m_grant ? !iAWrite : iCReadEnable);
        chk("mem_we", oDWriteEnable, iRST ? 1'b0 : m_grant ? iAWrite : iCWriteEnable);
        chk("cpu_rdata", oCReadData, iDReadData);
        if (!iRST) begin
            chk("mem_be", oDByteEnable, m_grant ? iAByteEnable : iCByteEnable);
            chk("mem_addr", oDAddress, m_grant ? iAAddress : iCAddress);
            chk("mem_wdata", oDWriteData, m_grant ? iAWriteData : iCWriteData);
        end
        if (m_known) begin
            chk("aux_ack", oAAck, m_ack);
            chk("aux_rdata", oAReadData, m_rd);
        end
        if (iRST) begin
            m_known = 1; m_ack = 0; m_wait = 0; m_rd = '0;
        end else begin
            if (m_grant && !iAWrite) m_rd = iDReadData;
            if (m_grant || !iAReq || m_ack) m_wait = 0;
            else if (m_cpu && m_wait < MAX_WAIT) m_wait++;
            m_ack = m_grant;
        end
    end

    task automatic tick; @(posedge iCLK); #1; endtask
    task automatic mid;  @(negedge iCLK); #1; endtask

    task automatic quiet;
        iCReadEnable = 0; iCWriteEnable = 0; iCByteEnable = 4'hF;
        iCAddress = 32'h0; iCWriteData = 32'h0;
        iAReq = 0; iAWrite = 0; iAByteEnable = 4'hF; iAAddress = 32'h0; iAWriteData = 32'h0;
    endtask

    int mode;

    initial begin
        quiet();
        iRST = 1; iAReq = 1; iCReadEnable = 1; iDReadData = 32'hDEADBEEF;
        tick(); tick(); mid();
        chk("rst_ack", oAAck, 0);
        chk("rst_stall", oCPUStall, 0);
        chk("rst_re", oDReadEnable, 0);
        chk("rst_rdata", oAReadData, 0);
        tick();
        iRST = 0; quiet();

        // aux read with idle CPU
        iAReq = 1; iAAddress = 32'h10010000;
        mid();
        chk("rd_addr", oDAddress, 32'h10010000);
        chk("rd_re", oDReadEnable, 1);
        chk("rd_stall", oCPUStall, 0);
        tick(); iAReq = 0;
        mid();
        chk("rd_ack", oAAck, 1);
        chk("rd_data", oAReadData, 32'hDEADBEEF);
        tick();

        // starvation with the CPU reading every cycle
        iCReadEnable = 1; iCAddress = 32'h10010004; iAReq = 1; iAAddress = 32'h20000000;
        for (int i = 0; i < MAX_WAIT; i++) begin
            mid();
            chk("starve_addr", oDAddress, 32'h10010004);
            chk("starve_nostall", oCPUStall, 0);
            tick();
        end
        mid();
        chk("starve_stall", oCPUStall, 1);
        chk("starve_aux_addr", oDAddress, 32'h20000000);
        tick(); iAReq = 0;
        mid();
        chk("starve_ack", oAAck, 1);
        chk("starve_unstall", oCPUStall, 0);
        tick(); quiet();

        // aux byte write
        iAReq = 1; iAWrite = 1; iAByteEnable = 4'b0010; iAWriteData = 32'h0000AB00;
        mid();
        chk("wr_we", oDWriteEnable, 1);
        chk("wr_be", oDByteEnable, 4'b0010);
        chk("wr_data", oDWriteData, 32'h0000AB00);
        tick(); iAReq = 0;
        mid();
        chk("wr_we_off", oDWriteEnable, 0);
        chk("wr_ack", oAAck, 1);
        chk("wr_rdata_kept", oAReadData, 32'hDEADBEEF);
        tick(); quiet();

        // held request: grants two cycles apart
        iAReq = 1;
        mid(); chk("held_g0", oDReadEnable, 1); tick();
        mid(); chk("held_ack0", oAAck, 1); chk("held_no_g", oDReadEnable, 0); tick();
        mid(); chk("held_gap", oAAck, 0); chk("held_g1", oDReadEnable, 1); tick();
        iAReq = 0;
        mid(); chk("held_ack1", oAAck, 1); tick();

        // reset in the ACK cycle
        iDReadData = 32'h12345678; iAReq = 1;
        tick(); iAReq = 0; iRST = 1;
        mid(); chk("rack_ack", oAAck, 1); chk("rack_rdata", oAReadData, 32'h12345678);
        tick(); iRST = 0;
        mid(); chk("rack_ack_clr", oAAck, 0); chk("rack_rdata_clr", oAReadData, 0);
        tick();

        // randomized traffic, aux fields held stable while a request is pending
        for (int n = 0; n < 3000; n++) begin
            mode = (n / 400) % 3;
            iRST = ($urandom_range(0, 299) == 0);
            iCReadEnable  = mode == 1 ? 1'b1 : mode == 0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            iCWriteEnable = mode == 1 ? 1'b0 : ($urandom_range(0, 3) == 0);
            iCByteEnable = 4'($urandom); iCAddress = $urandom; iCWriteData = $urandom;
            iDReadData = $urandom;
            if (iAReq && oAAck) iAReq = 1'($urandom_range(0, 1));
            else if (!iAReq) begin
                iAReq = ($urandom_range(0, 2) == 0);
                iAWrite = 1'($urandom); iAByteEnable = 4'($urandom);
                iAAddress = $urandom; iAWriteData = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Shares the single data-memory bus between the uniciclo CPU datapath and one auxiliary master, such as the bootloader or a DMA/debug engine. The CPU has priority because a single-cycle core cannot wait on memory. The auxiliary master uses a request/acknowledge handshake. If it is denied for too long, the arbiter asserts a one-cycle CPU stall and takes the bus for it. The block sits between the datapath's Dw* bus and the data memory.

## Interface
Parameters:
- MAX_WAIT, 16: number of consecutive denied cycles before the aux master is forcibly granted. Legal range 1..255.

Ports:
- iCLK  in  1  system clock; the only clock.
- iRST  in  1  reset, synchronous, active-high.
- iCReadEnable, iCWriteEnable  in  1  CPU read/write strobes.
- iCByteEnable  in  4  CPU byte enables.
- iCAddress, iCWriteData  in  32  CPU address and write data.
- oCReadData  out  32  CPU read data; always equal to iDReadData.
- oCPUStall  out  1  CPU must not update PC, register file or COP0 this cycle.
- iAReq  in  1  aux request; held high until ack.
- iAWrite  in  1  aux direction: 1 = write, 0 = read.
- iAByteEnable  in  4  aux byte enables.
- iAAddress, iAWriteData  in  32  aux address and write data.
- oAAck  out  1  one-cycle completion pulse.
- oAReadData  out  32  registered aux read data.
- oDReadEnable, oDWriteEnable  out  1  memory strobes.
- oDByteEnable  out  4  memory byte enables.
- oDAddress, oDWriteData  out  32  memory address and write data.
- iDReadData  in  32  memory read data; combinational.

## Operation
- CPU active: cpu_act = iCReadEnable | iCWriteEnable.
- States:
  - IDLE: the CPU owns the bus unless aux is granted this cycle.
  - ACK: oAAck = 1; the bus belongs to the CPU.
- Grant condition, evaluated only in IDLE: iAReq & (~cpu_act | wait_cnt == MAX_WAIT).
- Forced grant: a grant with cpu_act = 1 asserts oCPUStall in the same cycle, combinationally. oCPUStall is asserted at no other time.
- Grant cycle:
  - Bus mux selects aux.
  - oDReadEnable = ~iAWrite; oDWriteEnable = iAWrite.
  - oDByteEnable, oDAddress, oDWriteData come from the aux port.
  - On read, iDReadData is latched into oAReadData at the clock edge.
  - Next state is ACK.
- Non-grant cycles: the bus mux passes the CPU signals unchanged.
- ACK → IDLE unconditionally. iAReq sampled in ACK is ignored. A held request competes again from the next IDLE cycle.
- wait_cnt (8 bits, saturating at MAX_WAIT):
  - Cleared on grant, on iAReq = 0, and in ACK.
  - Incremented in IDLE when iAReq & cpu_act and no grant.
- During a stalled cycle the CPU's access is dropped from the bus. The CPU re-presents it next cycle because the PC is frozen.
- oAReadData keeps its value until the next aux read grant. After a write it is unchanged.

## Timing
- Reset values, at the first edge with iRST = 1:
  - State IDLE, wait_cnt = 0, oAAck = 0, oAReadData = 0.
  - oCPUStall is forced to 0 while iRST = 1.
  - oDReadEnable and oDWriteEnable are forced to 0 while iRST = 1.
- Aux latency with the CPU idle: grant in the cycle iAReq is first seen; oAAck one cycle later. Minimum request-to-ack is 1 cycle.
- Aux latency with the CPU busy every cycle: denied cycles 0..MAX_WAIT-1 after the request; stall plus grant at cycle MAX_WAIT; ack at MAX_WAIT+1.
- Simultaneous events:
  - CPU idle and aux request in the same cycle: aux is granted, no stall.
  - CPU active and aux request with wait_cnt < MAX_WAIT: CPU served, aux waits.
- Back-to-back aux requests: at most one aux grant every 2 cycles.
- Reset mid-transaction: reset in ACK clears oAAck at that edge. Reset in the grant cycle discards the pending ack; the aux master must re-request.
- The aux master must hold its address, data, direction and byte enables stable from request until ack. Changes in that window are undefined.

## Test plan
- Reset: hold iRST 2 cycles with iAReq = 1 and iCReadEnable = 1 → oAAck = 0, oCPUStall = 0, oDReadEnable = 0, oAReadData = 0.
- Idle aux read: mem[0x10010000] = 0xDEADBEEF, CPU idle, iAReq = 1 and iAWrite = 0 at cycle 0 → cycle 0: oDAddress = 0x10010000 and oDReadEnable = 1; cycle 1: oAAck = 1 and oAReadData = 0xDEADBEEF; no stall.
- Starvation (MAX_WAIT = 4): CPU reads 0x10010004 every cycle, aux requests at cycle 0 → cycles 0–3 bus shows the CPU address; cycle 4 oCPUStall = 1 and bus shows the aux address; cycle 5 oAAck = 1 and oCPUStall = 0.
- Aux byte write: CPU idle, iAWrite = 1, iAByteEnable = 4'b0010, iAWriteData = 0x0000AB00 → oDWriteEnable high for exactly 1 cycle with oDByteEnable = 4'b0010; oAAck on the next cycle.
- Held request: iAReq kept high through the ACK cycle → second grant in the cycle after ACK; acks spaced exactly 2 cycles apart.
- Reset during ACK: assert iRST in the ACK cycle → oAAck = 0 after that edge, wait_cnt = 0, oAReadData = 0.
